// File: rtl/alarm_pkg.sv
// Shared types for the alarm bank: FSM states, the {hour, min} record and the
// BCD preset validity check.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
    } hm_t;

    // Both nibbles must be decimal digits and the value must be a legal time of day.
    function automatic logic hm_valid(input hm_t t);
        return (t.hour[3:0] <= 4'd9) && (t.min[3:0] <= 4'd9) &&
               (t.hour <= 8'h23) && (t.min[7:4] <= 4'd5);
    endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm channel: stored preset, arm bit, match detect and the fired flag
// that limits each channel to one trigger per matching minute.
module alarm_slot
    import alarm_pkg::*;
(
    input  logic clk,
    input  logic CR,
    input  logic we,
    input  logic pre_on,
    input  hm_t  pre_time,
    input  hm_t  show_time,
    output hm_t  stored,
    output logic trigger
);

    hm_t  time_q, time_d;
    logic on_q, on_d;
    logic fired_q, fired_d;
    logic match;

    always_comb begin
        match   = on_q && (time_q == show_time);
        trigger = match && !fired_q;
        stored  = time_q;
    end

    always_comb begin
        time_d  = time_q;
        on_d    = on_q;
        fired_d = match;
        if (we) begin
            time_d = pre_time;
            on_d   = pre_on;
        end
    end

    always_ff @(posedge clk) begin
        if (CR) begin
            time_q  <= '0;
            on_q    <= 1'b0;
            fired_q <= 1'b0;
        end else begin
            time_q  <= time_d;
            on_q    <= on_d;
            fired_q <= fired_d;
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// Bank of NUM_ALARMS alarm channels sharing one ring/snooze controller with a
// rotating indicator-light pattern while ringing.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS  = 4,
    parameter int LIGHT_W     = 16,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic               clk,
    input  logic               CR,
    input  logic               sec_tick,
    input  logic               PE,
    input  logic [SEL_W-1:0]   sel,
    input  logic [7:0]         pre_hour,
    input  logic [7:0]         pre_min,
    input  logic               pre_on,
    input  logic [7:0]         show_hour,
    input  logic [7:0]         show_min,
    input  logic               ack,
    input  logic               snooze,
    output logic [LIGHT_W-1:0] start_light,
    output logic [15:0]        alarm_time,
    output logic               ringing,
    output logic               snoozing,
    output logic [SEL_W-1:0]   ring_ch,
    output logic               load_err
);

    localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CNT_W    = (MAX_SECS > 1) ? $clog2(MAX_SECS) : 1;
    localparam int SNZ_W    = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SNZ_W-1:0]     snz_q, snz_d;
    logic [LIGHT_W-1:0]   light_q, light_d;
    logic [SEL_W-1:0]     ring_ch_q, ring_ch_d;
    logic                 load_err_q, load_err_d;

    hm_t                  pre_time, show_time;
    hm_t                  slot_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] trig;
    logic                 pre_ok;
    logic                 any_trig;
    logic [SEL_W-1:0]     win;

    always_comb begin
        pre_time   = '{hour: pre_hour, min: pre_min};
        show_time  = '{hour: show_hour, min: show_min};
        pre_ok     = hm_valid(pre_time);
        load_err_d = PE && !pre_ok;
    end

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
        alarm_slot u_slot (
            .clk       (clk),
            .CR        (CR),
            .we        (PE && pre_ok && (sel == SEL_W'(gi))),
            .pre_on    (pre_on),
            .pre_time  (pre_time),
            .show_time (show_time),
            .stored    (slot_time[gi]),
            .trigger   (trig[gi])
        );
    end

    always_comb begin
        alarm_time = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (sel == SEL_W'(i)) alarm_time = slot_time[i];
        end
    end

    // Lowest-index triggering channel wins.
    always_comb begin
        any_trig = 1'b0;
        win      = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (trig[i] && !any_trig) begin
                any_trig = 1'b1;
                win      = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (CR) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            snz_q      <= '0;
            light_q    <= '0;
            ring_ch_q  <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snz_q      <= snz_d;
            light_q    <= light_d;
            ring_ch_q  <= ring_ch_d;
            load_err_q <= load_err_d;
        end
    end

    // User requests are tested before the tick so they beat a same-cycle expiry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        snz_d     = snz_q;
        light_d   = light_q;
        ring_ch_d = ring_ch_q;
        case (state_q)
            ST_IDLE: begin
                if (any_trig) begin
                    state_d   = ST_RING;
                    ring_ch_d = win;
                    cnt_d     = '0;
                    snz_d     = '0;
                    light_d   = LIGHT_W'(1);
                end
            end
            ST_RING: begin
                if (ack) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    light_d = '0;
                end else if (snooze && (snz_q < SNZ_W'(MAX_SNOOZE))) begin
                    state_d = ST_SNOOZE;
                    cnt_d   = '0;
                    light_d = '0;
                end else if (sec_tick) begin
                    if (cnt_q == RING_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        light_d = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        light_d = (light_q << 1) | (light_q >> (LIGHT_W - 1));
                    end
                end
            end
            ST_SNOOZE: begin
                if (ack) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sec_tick) begin
                    if (cnt_q == SNOOZE_LAST) begin
                        state_d = ST_RING;
                        cnt_d   = '0;
                        snz_d   = snz_q + SNZ_W'(1);
                        light_d = LIGHT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                light_d = '0;
            end
        endcase
    end

    always_comb begin
        ringing     = (state_q == ST_RING);
        snoozing    = (state_q == ST_SNOOZE);
        start_light = light_q;
        ring_ch     = ring_ch_q;
        load_err    = load_err_q;
    end

endmodule
